// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message schedule generator: loads one 512-bit block and streams
// W_0..W_{ROUNDS-1} over a valid/ready handshake from a 16-word sliding window.
module sha256_w_sched_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         last,
    output logic         busy
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    logic [0:0]  state_reg;
    logic [5:0]  t_reg;
    logic [31:0] win_reg [16];
    logic [31:0] w_new;
    logic        load;
    logic        xfer;
    logic        shift;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign load  = (state_reg == IDLE) && in_valid;
    assign xfer  = (state_reg == RUN) && out_ready;
    assign shift = xfer && !abort;

    // win_reg[0] is W_t; the word entering at slot 15 is W_{t+16}
    assign w_new = ssig1(win_reg[14]) + win_reg[9] + ssig0(win_reg[1]) + win_reg[0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            t_reg     <= 6'd0;
        end else if (state_reg == IDLE) begin
            if (in_valid) begin
                state_reg <= RUN;
                t_reg     <= 6'd0;
            end
        end else if (abort) begin
            state_reg <= IDLE;
            t_reg     <= 6'd0;
        end else if (xfer) begin
            if (t_reg == LAST_IDX) begin
                state_reg <= IDLE;
                t_reg     <= 6'd0;
            end else begin
                t_reg <= t_reg + 6'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_win
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    win_reg[gi] <= 32'd0;
                end else if (load) begin
                    win_reg[gi] <= block_in[511 - 32*gi -: 32];
                end else if (shift) begin
                    if (gi < 15) begin
                        win_reg[gi] <= win_reg[(gi < 15) ? gi + 1 : gi];
                    end else begin
                        win_reg[gi] <= w_new;
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign out_valid = (state_reg == RUN);
    assign w_out     = win_reg[0];
    assign w_idx     = t_reg;
    assign last      = (state_reg == RUN) && (t_reg == LAST_IDX);

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// Directed bench for sha256_w_sched_ctrl: "abc" schedule, stalls, abort,
// mid-run reset, back-to-back loads and a ROUNDS=16 build.
module tb_sha256_w_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, abort, out_ready;
    logic [511:0] block_in;
    logic         in_ready, out_valid, last, busy;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;

    logic         in_valid_16, out_ready_16, abort_16;
    logic         in_ready_16, out_valid_16, last_16, busy_16;
    logic [31:0]  w_out_16;
    logic [5:0]   w_idx_16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  exp_w [64];
    logic [511:0] abc_blk;
    logic [511:0] blk_b;

    always #5 clk = ~clk;

    sha256_w_sched_ctrl #(.ROUNDS(64)) dut (
        .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .w_out(w_out), .w_idx(w_idx), .last(last), .busy(busy)
    );

    sha256_w_sched_ctrl #(.ROUNDS(16)) dut16 (
        .CLK(clk), .RST(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
        .block_in(block_in), .abort(abort_16), .out_valid(out_valid_16),
        .out_ready(out_ready_16), .w_out(w_out_16), .w_idx(w_idx_16), .last(last_16), .busy(busy_16)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule built the textbook way over a full 64-entry array
    task automatic build_sched(input logic [511:0] b);
        for (int i = 0; i < 64; i++) begin
            if (i < 16) exp_w[i] = b[511 - 32*i -: 32];
            else exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
                          + exp_w[i-7]
                          + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
                          + exp_w[i-16];
        end
    endtask

    task automatic do_load();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(output bit timed_out);
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (busy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        timed_out = (cyc >= 100);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; abort = 0; out_ready = 0; block_in = '0;
        in_valid_16 = 0; out_ready_16 = 0; abort_16 = 0;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b want=0", last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (w_out !== 32'd0) begin n_fail++; $display("FAIL reset_w_out got=%h want=0", w_out); end
        n_checks++; if (w_idx !== 6'd0) begin n_fail++; $display("FAIL reset_w_idx got=%0d want=0", w_idx); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_checks++; if (in_ready_16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready16 got=%b want=1", in_ready_16); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%b want=0", out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_abc();
        build_sched(abc_blk);
        block_in = abc_blk; out_ready = 1'b1;
        do_load();
        for (int cnt = 0; cnt < 64; cnt++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL abc_valid t=%0d got=%b want=1", cnt, out_valid); end
            n_checks++; if (w_idx !== 6'(cnt)) begin n_fail++; $display("FAIL abc_idx got=%0d want=%0d", w_idx, cnt); end
            n_checks++; if (w_out !== exp_w[cnt]) begin n_fail++; $display("FAIL abc_w t=%0d got=%h want=%h", cnt, w_out, exp_w[cnt]); end
            n_checks++; if (last !== (cnt == 63)) begin n_fail++; $display("FAIL abc_last t=%0d got=%b want=%b", cnt, last, (cnt == 63)); end
            if (cnt == 0)  begin n_checks++; if (w_out !== 32'h61626380) begin n_fail++; $display("FAIL abc_w0 got=%h want=61626380", w_out); end end
            if (cnt == 15) begin n_checks++; if (w_out !== 32'h00000018) begin n_fail++; $display("FAIL abc_w15 got=%h want=00000018", w_out); end end
            if (cnt == 16) begin n_checks++; if (w_out !== 32'h61626380) begin n_fail++; $display("FAIL abc_w16 got=%h want=61626380", w_out); end end
            if (cnt == 17) begin n_checks++; if (w_out !== 32'h000F0000) begin n_fail++; $display("FAIL abc_w17 got=%h want=000F0000", w_out); end end
            @(posedge clk); #1;
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abc_end_valid got=%b want=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abc_end_in_ready got=%b want=1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abc_end_busy got=%b want=0", busy); end
        $display("test_abc done: 64 words streamed");
    endtask

    task automatic test_stall();
        int cnt, cyc, stalls;
        bit prev_stall;
        logic [31:0] prev_w;
        logic [5:0]  prev_idx;
        build_sched(abc_blk);
        block_in = abc_blk; out_ready = 1'b0;
        do_load();
        cnt = 0; cyc = 0; stalls = 0; prev_stall = 0; prev_w = '0; prev_idx = '0;
        while (cnt < 64 && cyc < 1000) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid t=%0d got=%b want=1", cnt, out_valid); end
            n_checks++; if (w_idx !== 6'(cnt)) begin n_fail++; $display("FAIL stall_idx got=%0d want=%0d", w_idx, cnt); end
            n_checks++; if (w_out !== exp_w[cnt]) begin n_fail++; $display("FAIL stall_w t=%0d got=%h want=%h", cnt, w_out, exp_w[cnt]); end
            if (prev_stall) begin
                n_checks++; if (w_out !== prev_w || w_idx !== prev_idx) begin
                    n_fail++; $display("FAIL stall_hold got=%h/%0d want=%h/%0d", w_out, w_idx, prev_w, prev_idx); end
            end
            prev_w = w_out; prev_idx = w_idx;
            out_ready = 1'($urandom_range(0, 1));
            prev_stall = !out_ready;
            if (out_ready) cnt++; else stalls++;
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (cnt != 64) begin n_fail++; $display("FAIL stall_timeout got=%0d words want=64", cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid got=%b want=0", out_valid); end
        $display("test_stall done: %0d stalled cycles", stalls);
    endtask

    task automatic test_abort();
        bit to;
        build_sched(abc_blk);
        block_in = abc_blk; out_ready = 1'b1;
        do_load();
        repeat (20) begin @(posedge clk); #1; end
        n_checks++; if (w_idx !== 6'd20) begin n_fail++; $display("FAIL abort_pre_idx got=%0d want=20", w_idx); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got=%b want=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got=%b want=1", in_ready); end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle_valid got=%b want=0", out_valid); end
        // abort together with in_valid in IDLE must still load
        build_sched(blk_b);
        block_in = blk_b; abort = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL reload_valid got=%b want=1", out_valid); end
        n_checks++; if (w_idx !== 6'd0) begin n_fail++; $display("FAIL reload_idx got=%0d want=0", w_idx); end
        n_checks++; if (w_out !== 32'h01000000) begin n_fail++; $display("FAIL reload_w0 got=%h want=01000000", w_out); end
        @(posedge clk); #1;
        n_checks++; if (w_out !== exp_w[1]) begin n_fail++; $display("FAIL reload_w1 got=%h want=%h", w_out, exp_w[1]); end
        drain(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL abort_drain_timeout got=busy want=idle"); end
        $display("test_abort done");
    endtask

    task automatic test_reset_mid();
        block_in = abc_blk; out_ready = 1'b1;
        do_load();
        repeat (40) begin @(posedge clk); #1; end
        n_checks++; if (w_idx !== 6'd40) begin n_fail++; $display("FAIL rstmid_pre_idx got=%0d want=40", w_idx); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
        n_checks++; if (w_out !== 32'd0) begin n_fail++; $display("FAIL rstmid_w_out got=%h want=0", w_out); end
        n_checks++; if (w_idx !== 6'd0) begin n_fail++; $display("FAIL rstmid_w_idx got=%0d want=0", w_idx); end
        n_checks++; if (busy !== 1'b0 || last !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_last got=%b%b want=00", busy, last); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL rstmid_spurious got=valid%b/ready%b want=valid0/ready1", out_valid, in_ready); end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        bit to;
        build_sched(abc_blk);
        block_in = abc_blk; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        block_in = blk_b;
        for (int cnt = 0; cnt < 64; cnt++) begin
            n_checks++; if (w_idx !== 6'(cnt) || w_out !== exp_w[cnt]) begin
                n_fail++; $display("FAIL b2b_word t=%0d got=%h/%0d want=%h/%0d", cnt, w_out, w_idx, exp_w[cnt], cnt); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_run t=%0d got=%b want=0", cnt, in_ready); end
            @(posedge clk); #1;
        end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle_gap got=valid%b/ready%b want=valid0/ready1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || w_idx !== 6'd0) begin
            n_fail++; $display("FAIL b2b_second_start got=valid%b/idx%0d want=valid1/idx0", out_valid, w_idx); end
        n_checks++; if (w_out !== 32'h01000000) begin n_fail++; $display("FAIL b2b_second_w0 got=%h want=01000000", w_out); end
        drain(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_drain_timeout got=busy want=idle"); end
        $display("test_back_to_back done");
    endtask

    task automatic test_rounds16();
        build_sched(abc_blk);
        block_in = abc_blk; out_ready_16 = 1'b1; in_valid_16 = 1'b1;
        @(posedge clk); #1;
        in_valid_16 = 1'b0;
        for (int cnt = 0; cnt < 16; cnt++) begin
            n_checks++; if (out_valid_16 !== 1'b1 || w_idx_16 !== 6'(cnt)) begin
                n_fail++; $display("FAIL r16_valid_idx got=%b/%0d want=1/%0d", out_valid_16, w_idx_16, cnt); end
            n_checks++; if (w_out_16 !== exp_w[cnt]) begin n_fail++; $display("FAIL r16_w t=%0d got=%h want=%h", cnt, w_out_16, exp_w[cnt]); end
            n_checks++; if (last_16 !== (cnt == 15)) begin n_fail++; $display("FAIL r16_last t=%0d got=%b want=%b", cnt, last_16, (cnt == 15)); end
            @(posedge clk); #1;
        end
        n_checks++; if (out_valid_16 !== 1'b0 || in_ready_16 !== 1'b1) begin
            n_fail++; $display("FAIL r16_end got=valid%b/ready%b want=valid0/ready1", out_valid_16, in_ready_16); end
        $display("test_rounds16 done");
    endtask

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = 32'h01000000 * (i + 1) + 32'(i);
        test_reset();
        test_abc();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_rounds16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_w_sched_ctrl.md
SHA256_W_SCHED_CTRL -- requirements
Module: sha256_w_sched_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 64, meaning the number of schedule words emitted per block (legal range 16..64).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  block_in is valid.
REQ-005 SHALL have port in_ready  output  1  the block accepts a new block.
REQ-006 SHALL have port block_in  input  512  message block, with word 0 = block_in[511:480] and word 15 = block_in[31:0].
REQ-007 SHALL have port abort  input  1  synchronous cancel of the block in progress.
REQ-008 SHALL have port out_valid  output  1  w_out is valid.
REQ-009 SHALL have port out_ready  input  1  the consumer accepts w_out.
REQ-010 SHALL have port w_out  output  32  schedule word W_t.
REQ-011 SHALL have port w_idx  output  6  index t of w_out.
REQ-012 SHALL have port last  output  1  high with out_valid when t = ROUNDS-1.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; in_ready SHALL equal (state==IDLE), and busy SHALL equal (state==RUN).
REQ-015 On a rising edge with in_valid&in_ready in IDLE, the block SHALL load the 16 words into a 16x32 sliding window, set t=0 and enter RUN.
REQ-016 The block SHALL present out_valid=1, w_idx=0 and w_out=word 0 in the cycle after the load edge, giving 1-cycle latency.
REQ-017 For t<16, w_out SHALL equal word t.
REQ-018 For t>=16, w_out SHALL equal sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], computed mod 2^32 with carries discarded.
REQ-019 sigma0 SHALL be ROTR7 ^ ROTR18 ^ SHR3.
REQ-020 sigma1 SHALL be ROTR17 ^ ROTR19 ^ SHR10.
REQ-021 A transfer SHALL occur on a rising edge where out_valid&out_ready; on a transfer, t SHALL increment and the window SHALL shift one word, with the new W entering.
REQ-022 While out_valid&!out_ready, w_out, w_idx and last SHALL hold stable, and no window shift SHALL occur.
REQ-023 A transfer with last=1 SHALL return the FSM to IDLE, with out_valid=0 and in_ready=1 in the next cycle; a new block SHALL NOT be accepted in that same edge.
REQ-024 in_valid in RUN SHALL be ignored, and block_in SHALL NOT be sampled.
REQ-025 abort=1 on any edge in RUN SHALL force IDLE with out_valid=0 in the next cycle, discarding any concurrent transfer as a completed word.
REQ-026 abort in IDLE SHALL have no effect.
REQ-027 If abort and in_valid are both high in IDLE, the load SHALL take place.
REQ-028 The t counter SHALL never exceed ROUNDS-1.
REQ-029 With ROUNDS=16, no expansion words SHALL be emitted.
REQ-030 All outputs SHALL be registered or derived from state only, with no combinational path from out_ready or in_valid to any output.

Reset
REQ-031 RST=0 SHALL asynchronously force state=IDLE, t=0 and window=0.
REQ-032 During reset, out_valid=0, last=0, busy=0, w_out=0, w_idx=0 and in_ready=1.
REQ-033 Reset asserted mid-RUN SHALL discard the block, with no further words emitted after release until a new load.
REQ-034 Release of RST SHALL take effect on the first rising edge after deassertion.

Verification
REQ-035 Load the FIPS-180 "abc" padded block (word 0=0x61626380, words 1..14=0, word 15=0x00000018) with out_ready=1 -> W_0=0x61626380, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000, and 64 transfers with last on w_idx=63, then in_ready=1.
REQ-036 Same block with out_ready toggled pseudo-randomly -> an identical W sequence, and w_out/w_idx stable in every stalled cycle.
REQ-037 Pulse abort at w_idx=20 with out_ready=1 -> out_valid=0 the next cycle, busy=0, in_ready=1, and a subsequent load restarting at w_idx=0.
REQ-038 Assert RST low at w_idx=40, then release -> all outputs at reset values and no spurious out_valid.
REQ-039 Hold in_valid=1 continuously with a second block -> the second block is accepted only in the IDLE cycle after last, and its W_0 appears one cycle after that.
REQ-040 ROUNDS=16 build with the "abc" block -> 16 words equal to the input words, and last at w_idx=15.
